// File: rtl/sprite_blitter.sv
// Streams an IMG_W x IMG_H image from a 1-cycle synchronous ROM onto the VGA pixel port
// at a latched origin, with colour-key transparency and screen-edge clipping.
module sprite_blitter #(
    parameter int unsigned           IMG_W      = 80,
    parameter int unsigned           IMG_H      = 40,
    parameter int unsigned           ADDR_W     = 12,
    parameter int unsigned           COLOUR_W   = 9,
    parameter int unsigned           SCREEN_W   = 160,
    parameter int unsigned           SCREEN_H   = 120,
    parameter bit                    KEY_EN     = 1'b1,
    parameter logic [COLOUR_W-1:0]   KEY_COLOUR = '0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [7:0]          x_origin,
    input  logic [6:0]          y_origin,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H + 1) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_pv;
    logic [COL_W-1:0]    r_px;
    logic [ROW_W-1:0]    r_py;
    logic [7:0]          r_x_lat;
    logic [6:0]          r_y_lat;
    logic                r_done;

    logic                w_col_end;
    logic                w_last;
    logic [8:0]          w_x_sum;
    logic [7:0]          w_y_sum;
    logic                w_in_screen;
    logic                w_keyed;

    assign w_col_end = (r_col == COL_W'(IMG_W - 1));
    assign w_last    = w_col_end && (r_row == ROW_W'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_nxt = StRun;
            StRun:   if (w_last) w_state_nxt = StFlush;
            StFlush: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_pv    <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
            r_x_lat <= '0;
            r_y_lat <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_x_lat <= x_origin;
                        r_y_lat <= y_origin;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_addr  <= '0;
                    end
                end
                StRun: begin
                    // Pixel coordinates follow the address by one cycle to match the ROM latency.
                    r_pv   <= 1'b1;
                    r_px   <= r_col;
                    r_py   <= r_row;
                    r_addr <= r_addr + ADDR_W'(1);
                    if (w_col_end) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                StFlush: begin
                    r_pv   <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_x_sum     = {1'b0, r_x_lat} + 9'(r_px);
    assign w_y_sum     = {1'b0, r_y_lat} + 8'(r_py);
    assign w_in_screen = (w_x_sum < 9'(SCREEN_W)) && (w_y_sum < 8'(SCREEN_H));
    assign w_keyed     = KEY_EN && (rom_q == KEY_COLOUR);

    assign rom_addr = r_addr;
    assign x        = w_x_sum[7:0];
    assign y        = w_y_sum[6:0];
    assign colour   = rom_q;
    assign plot     = r_pv & w_in_screen & ~w_keyed;
    assign busy     = (r_state != StIdle);
    assign done     = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized and directed bench for sprite_blitter: a 4x3 instance checked cycle by cycle
// against a per-draw timing model, plus a default-size instance checked for totals.
module tb_sprite_blitter;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int BW = 80;
    localparam int BH = 40;
    localparam int BN = BW * BH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, start;
    logic [7:0] x_origin;
    logic [6:0] y_origin;
    logic [3:0] rom_addr;
    logic [8:0] rom_q, colour;
    logic [7:0] x;
    logic [6:0] y;
    logic       plot, busy, done;

    logic        resetn_big, start_big;
    logic [7:0]  x_origin_big;
    logic [6:0]  y_origin_big;
    logic [11:0] rom_addr_big;
    logic [8:0]  rom_q_big, colour_big;
    logic [7:0]  x_big;
    logic [6:0]  y_big;
    logic        plot_big, busy_big, done_big;

    logic [8:0] rom     [0:15];
    logic [8:0] rom_big [0:4095];

    always @(posedge clk) rom_q     <= rom[rom_addr];
    always @(posedge clk) rom_q_big <= rom_big[rom_addr_big];

    sprite_blitter #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(4), .COLOUR_W(9), .SCREEN_W(160), .SCREEN_H(120),
        .KEY_EN(1'b1), .KEY_COLOUR(9'h000)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .x_origin(x_origin), .y_origin(y_origin),
        .rom_addr(rom_addr), .rom_q(rom_q), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .done(done)
    );

    sprite_blitter dut_big (
        .clk(clk), .resetn(resetn_big), .start(start_big), .x_origin(x_origin_big),
        .y_origin(y_origin_big), .rom_addr(rom_addr_big), .rom_q(rom_q_big), .x(x_big),
        .y(y_big), .colour(colour_big), .plot(plot_big), .busy(busy_big), .done(done_big)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Model of the small draw: m_tt is the cycle number relative to the accepted start.
    bit m_active = 0;
    bit m_fresh  = 0;
    int m_tt = 0, m_xl = 0, m_yl = 0;
    int n_obs = 0, n_exp = 0;

    int big_t = 0, big_plots = 0, big_lx = 0, big_ly = 0, big_done_t = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle();
        int  k;
        int  ex, ey;
        bit  e_busy, e_done, e_plot;
        e_busy = m_active && (m_tt >= 1) && (m_tt <= N + 1);
        e_done = m_active && (m_tt == N + 2);
        e_plot = 1'b0;
        k      = m_tt - 2;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        if (m_active && k >= 0 && k < N) begin
            ex     = m_xl + k % W;
            ey     = m_yl + k / W;
            e_plot = (ex < 160) && (ey < 120) && (rom[k] != 9'h000);
            chk("x", 32'(x), ex % 256);
            chk("y", 32'(y), ey % 128);
            chk("colour", 32'(colour), 32'(rom[k]));
            if (e_plot) n_exp++;
        end
        chk("plot", 32'(plot), 32'(e_plot));
        if (plot === 1'b1) n_obs++;
        if (m_active && m_tt >= 1 && m_tt <= N) chk("rom_addr", 32'(rom_addr), m_tt - 1);
        if (m_fresh) begin
            chk("rst_x", 32'(x), 0);
            chk("rst_y", 32'(y), 0);
            chk("rst_addr", 32'(rom_addr), 0);
        end
        if (e_done) chk("nplots", n_obs, n_exp);
        if (plot_big === 1'b1) begin
            big_plots++;
            big_lx = x_big;
            big_ly = y_big;
        end
        if (done_big === 1'b1 && big_done_t == 0) big_done_t = big_t;
    endtask

    task automatic step();
        @(posedge clk);
        if (!resetn) begin
            m_active = 0;
            m_fresh  = 1;
            m_xl     = 0;
            m_yl     = 0;
        end else if ((!m_active || m_tt >= N + 2) && start) begin
            m_active = 1;
            m_fresh  = 0;
            m_tt     = 1;
            m_xl     = x_origin;
            m_yl     = y_origin;
            n_obs    = 0;
            n_exp    = 0;
        end else if (m_active) begin
            m_tt++;
        end
        if (start_big) big_t = 1;
        else if (big_t > 0) big_t++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic cyc(input bit st);
        start = st;
        step();
        start = 1'b0;
    endtask

    initial begin
        int g;
        resetn = 0; resetn_big = 0; start = 0; start_big = 0;
        x_origin = 0; y_origin = 0; x_origin_big = 8'd39; y_origin_big = 7'd39;
        for (int i = 0; i < 16; i++) rom[i] = 9'(i + 1);
        for (int i = 0; i < 4096; i++) rom_big[i] = 9'((i % 511) + 1);

        @(negedge clk);
        cyc(0); cyc(0);
        resetn = 1; resetn_big = 1;
        cyc(0);

        // Plain draw at (10,20); the default-size instance starts alongside.
        x_origin = 10; y_origin = 20;
        start_big = 1;
        cyc(1);
        start_big = 0;
        repeat (15) cyc(0);

        // Keyed pixel 5.
        rom[5] = 9'h000;
        cyc(1);
        repeat (15) cyc(0);
        rom[5] = 9'd6;

        // Clipping at the bottom-right corner.
        x_origin = 158; y_origin = 118;
        cyc(1);
        repeat (15) cyc(0);

        // Re-pulsed start while busy, then back-to-back start in the done cycle.
        x_origin = 10; y_origin = 20;
        cyc(1);
        for (int i = 1; i <= 30; i++) cyc(i == 3 || i == 7 || i == 14);

        // Reset mid-draw, then a full redraw.
        cyc(1);
        for (int i = 1; i <= 5; i++) cyc(0);
        resetn = 0;
        cyc(0);
        resetn = 1;
        repeat (16) cyc(0);
        cyc(1);
        repeat (15) cyc(0);

        // Random phase.
        for (int chunk = 0; chunk < 8; chunk++) begin
            g = 0;
            while (m_active && m_tt < N + 2 && g < 2 * N) begin
                cyc(0);
                g++;
            end
            for (int i = 0; i < 16; i++)
                rom[i] = ($urandom % 4 == 0) ? 9'h000 : 9'($urandom_range(1, 511));
            for (int i = 0; i < 150; i++) begin
                x_origin = ($urandom % 2 == 1) ? 8'($urandom_range(150, 255)) : 8'($urandom);
                y_origin = ($urandom % 2 == 1) ? 7'($urandom_range(110, 127)) : 7'($urandom);
                resetn   = ($urandom % 60 != 0);
                cyc($urandom % 3 == 0);
                resetn   = 1;
            end
        end

        g = 0;
        while (big_done_t == 0 && g < 5000) begin
            cyc(0);
            g++;
        end
        chk("big_done_cycle", big_done_t, BN + 2);
        chk("big_plots", big_plots, BN);
        chk("big_last_x", big_lx, 39 + BW - 1);
        chk("big_last_y", big_ly, 39 + BH - 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
